// File: rtl/sram_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_arbiter_pkg : requester indices, size encodings, grant selection helper
// Revision 1.0
// ---------------------------------------------------------------------------
package sram_arbiter_pkg;

   localparam logic REQ_INST = 1'b0;
   localparam logic REQ_DATA = 1'b1;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   // Data wins; inst is chosen only when it is the sole requester.
   function automatic logic sel_grant(input logic [1:0] req);
      return (req[REQ_DATA] || !req[REQ_INST]) ? REQ_DATA : REQ_INST;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sram_arbiter_owner_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// owner_fifo : in-order record of which requester owns each accepted request
// Revision 1.0
// ---------------------------------------------------------------------------
module owner_fifo #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic push,
   input  logic pop,
   input  logic din,
   output logic full,
   output logic empty,
   output logic head
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [DEPTH-1:0] mem_q;
   logic [PW-1:0]    wr_q, wr_d;
   logic [PW-1:0]    rd_q, rd_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign head    = mem_q[rd_q];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Pointers are PW bits wide and DEPTH is a power of two, so they wrap for free.
   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (push_ok) wr_d = wr_q + 1'b1;
      if (pop_ok)  rd_d = rd_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= din;
   end

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_arbiter : two-requester (inst/data) arbiter onto one SRAM-like port
// Revision 1.0
// ---------------------------------------------------------------------------
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [1:0]  s_req,
   input  logic [1:0]  s_wr,
   input  logic [3:0]  s_size,
   input  logic [7:0]  s_wstrb,
   input  logic [63:0] s_addr,
   input  logic [63:0] s_wdata,
   output logic [1:0]  s_addr_ok,
   output logic [1:0]  s_data_ok,
   output logic [31:0] s_rdata,
   output logic        m_req,
   output logic        m_wr,
   output logic [1:0]  m_size,
   output logic [3:0]  m_wstrb,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic        m_addr_ok,
   input  logic        m_data_ok,
   input  logic [31:0] m_rdata
);

   logic lock_q, lock_d;
   logic grant_q, grant_d;
   logic grant_sel;
   logic handshake;
   logic pop;
   logic fifo_full, fifo_empty, fifo_head;

   assign grant_sel = lock_q ? grant_q : sel_grant(s_req);

   // Issue is also gated by resetn so nothing leaks out while reset is asserted.
   assign m_req     = resetn && !fifo_full && s_req[grant_sel];
   assign m_wr      = s_wr[grant_sel];
   assign m_size    = grant_sel ? s_size[3:2]    : s_size[1:0];
   assign m_wstrb   = grant_sel ? s_wstrb[7:4]   : s_wstrb[3:0];
   assign m_addr    = grant_sel ? s_addr[63:32]  : s_addr[31:0];
   assign m_wdata   = grant_sel ? s_wdata[63:32] : s_wdata[31:0];
   assign handshake = m_req && m_addr_ok;
   assign pop       = resetn && m_data_ok && !fifo_empty;
   assign s_rdata   = m_rdata;

   always_comb begin
      s_addr_ok            = '0;
      s_addr_ok[grant_sel] = handshake;
      s_data_ok            = '0;
      s_data_ok[fifo_head] = pop;
   end

   always_comb begin
      lock_d  = lock_q;
      grant_d = grant_q;
      if (handshake) begin
         lock_d  = 1'b0;
         grant_d = grant_sel;
      end else if (m_req) begin
         lock_d  = 1'b1;
         grant_d = grant_sel;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         lock_q  <= 1'b0;
         grant_q <= REQ_DATA;
      end else begin
         lock_q  <= lock_d;
         grant_q <= grant_d;
      end
   end

   owner_fifo #(
      .DEPTH (DEPTH)
   ) u_owner_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (handshake),
      .pop    (pop),
      .din    (grant_sel),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .head   (fifo_head)
   );

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sram_arbiter : scoreboard bench for sram_arbiter (DEPTH = 2)
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_sram_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic [1:0]  s_req, s_wr;
   logic [3:0]  s_size;
   logic [7:0]  s_wstrb;
   logic [63:0] s_addr, s_wdata;
   logic [1:0]  s_addr_ok, s_data_ok;
   logic [31:0] s_rdata;
   logic        m_req, m_wr;
   logic [1:0]  m_size;
   logic [3:0]  m_wstrb;
   logic [31:0] m_addr, m_wdata;
   logic        m_addr_ok, m_data_ok;
   logic [31:0] m_rdata;

   localparam logic [31:0] IADDR = 32'h1000_0040;
   localparam logic [31:0] DADDR = 32'h2000_0080;

   typedef struct {
      logic        idx;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   sram_arbiter #(.DEPTH(2)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .s_req     (s_req),
      .s_wr      (s_wr),
      .s_size    (s_size),
      .s_wstrb   (s_wstrb),
      .s_addr    (s_addr),
      .s_wdata   (s_wdata),
      .s_addr_ok (s_addr_ok),
      .s_data_ok (s_data_ok),
      .s_rdata   (s_rdata),
      .m_req     (m_req),
      .m_wr      (m_wr),
      .m_size    (m_size),
      .m_wstrb   (m_wstrb),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .m_addr_ok (m_addr_ok),
      .m_data_ok (m_data_ok),
      .m_rdata   (m_rdata)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_resp(input logic idx, input logic [31:0] data);
      exp_t e;
      e.idx  = idx;
      e.data = data;
      sb.push_back(e);
   endtask

   // Pops the oldest expected response, drives it and checks routing.
   task automatic respond(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         m_data_ok = 1'b1;
         m_rdata   = e.data;
         #2;
         chk({tag, "_data_ok"}, {62'd0, s_data_ok}, e.idx ? 64'd2 : 64'd1);
         chk({tag, "_rdata"}, {32'd0, s_rdata}, {32'd0, e.data});
         tick();
         m_data_ok = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetn    = 1'b0;
      s_req     = '0;
      s_wr      = 2'b10;
      s_size    = {2'd2, 2'd0};
      s_wstrb   = {4'hF, 4'h1};
      s_addr    = {DADDR, IADDR};
      s_wdata   = {32'hDDDD_1234, 32'h1111_5678};
      m_addr_ok = 1'b0;
      m_data_ok = 1'b0;
      m_rdata   = '0;
      repeat (3) tick();

      // Reset: nothing escapes even with all inputs asserted
      s_req = 2'b11; m_addr_ok = 1'b1; m_data_ok = 1'b1;
      #2;
      chk("rst_m_req", {63'd0, m_req}, 64'd0);
      chk("rst_addr_ok", {62'd0, s_addr_ok}, 64'd0);
      chk("rst_data_ok", {62'd0, s_data_ok}, 64'd0);
      tick();
      resetn = 1'b1; s_req = '0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
      #2;
      chk("idle_m_req", {63'd0, m_req}, 64'd0);
      chk("idle_count", {62'd0, dut.u_owner_fifo.count_q}, 64'd0);
      tick();

      // Simultaneous requests: data first, inst next cycle
      s_req = 2'b11; m_addr_ok = 1'b1;
      #2;
      chk("sim_addr_ok_d", {62'd0, s_addr_ok}, 64'd2);
      chk("sim_m_addr_d", {32'd0, m_addr}, {32'd0, DADDR});
      chk("sim_fields_d", {25'd0, m_wr, m_size, m_wstrb, 32'd0}, {25'd0, 1'b1, 2'd2, 4'hF, 32'd0});
      chk("sim_wdata_d", {32'd0, m_wdata}, 64'hDDDD_1234);
      expect_resp(1'b1, 32'h1111_0000);
      tick();
      s_req = 2'b01;
      #2;
      chk("sim_addr_ok_i", {62'd0, s_addr_ok}, 64'd1);
      chk("sim_m_addr_i", {32'd0, m_addr}, {32'd0, IADDR});
      chk("sim_fields_i", {57'd0, m_wr, m_size, m_wstrb}, {57'd0, 1'b0, 2'd0, 4'h1});
      expect_resp(1'b0, 32'h2222_0000);
      tick();
      s_req = '0; m_addr_ok = 1'b0;
      respond("sim_r0");
      respond("sim_r1");

      // Lock: inst stalls 3 cycles, data rises in cycle 2
      s_req = 2'b01; m_addr_ok = 1'b0;
      #2;
      chk("lock_c1_m_req", {63'd0, m_req}, 64'd1);
      chk("lock_c1_addr_ok", {62'd0, s_addr_ok}, 64'd0);
      chk("lock_c1_m_addr", {32'd0, m_addr}, {32'd0, IADDR});
      tick();
      for (int c = 2; c <= 3; c++) begin
         s_req = 2'b11;
         #2;
         chk("lock_hold_m_addr", {32'd0, m_addr}, {32'd0, IADDR});
         chk("lock_hold_addr_ok", {62'd0, s_addr_ok}, 64'd0);
         tick();
      end
      m_addr_ok = 1'b1;
      #2;
      chk("lock_acc_inst", {62'd0, s_addr_ok}, 64'd1);
      chk("lock_acc_m_addr", {32'd0, m_addr}, {32'd0, IADDR});
      expect_resp(1'b0, 32'hAAAA_0000);
      tick();
      s_req = 2'b10;
      #2;
      chk("lock_acc_data", {62'd0, s_addr_ok}, 64'd2);
      chk("lock_acc_d_addr", {32'd0, m_addr}, {32'd0, DADDR});
      expect_resp(1'b1, 32'hBBBB_0000);
      tick();
      s_req = '0; m_addr_ok = 1'b0;
      respond("order_r0");
      respond("order_r1");

      // Full FIFO: third request held off until a slot is freed
      s_req = 2'b01; m_addr_ok = 1'b1;
      for (int k = 0; k < 2; k++) begin
         #2;
         chk("full_fill_addr_ok", {62'd0, s_addr_ok}, 64'd1);
         expect_resp(1'b0, 32'hC000_0000 + 32'(k));
         tick();
      end
      #2;
      chk("full_m_req", {63'd0, m_req}, 64'd0);
      chk("full_addr_ok", {62'd0, s_addr_ok}, 64'd0);
      chk("full_count", {62'd0, dut.u_owner_fifo.count_q}, 64'd2);
      tick();
      begin
         exp_t e;
         e = sb.pop_front();
         m_data_ok = 1'b1;
         m_rdata   = e.data;
         #2;
         chk("full_pop_m_req", {63'd0, m_req}, 64'd0);
         chk("full_pop_data_ok", {62'd0, s_data_ok}, 64'd1);
         chk("full_pop_rdata", {32'd0, s_rdata}, {32'd0, e.data});
         tick();
      end
      m_data_ok = 1'b0;
      #2;
      chk("full_resume_m_req", {63'd0, m_req}, 64'd1);
      chk("full_resume_addr_ok", {62'd0, s_addr_ok}, 64'd1);
      expect_resp(1'b0, 32'hC000_0002);
      tick();
      s_req = '0; m_addr_ok = 1'b0;
      respond("full_r1");
      respond("full_r2");

      // Spurious response with empty FIFO
      m_data_ok = 1'b1; m_rdata = 32'hDEAD_BEEF;
      #2;
      chk("spur_data_ok", {62'd0, s_data_ok}, 64'd0);
      tick();
      m_data_ok = 1'b0;
      #2;
      chk("spur_count", {62'd0, dut.u_owner_fifo.count_q}, 64'd0);
      tick();

      // Reset with one request outstanding
      s_req = 2'b10; m_addr_ok = 1'b1;
      #2;
      chk("mid_acc", {62'd0, s_addr_ok}, 64'd2);
      tick();
      s_req = '0; m_addr_ok = 1'b0;
      #2;
      chk("mid_count1", {62'd0, dut.u_owner_fifo.count_q}, 64'd1);
      tick();
      resetn = 1'b0; s_req = 2'b11; m_addr_ok = 1'b1;
      #2;
      chk("mid_rst_m_req", {63'd0, m_req}, 64'd0);
      chk("mid_rst_addr_ok", {62'd0, s_addr_ok}, 64'd0);
      tick();
      resetn = 1'b1; s_req = '0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
      #2;
      chk("mid_post_count", {62'd0, dut.u_owner_fifo.count_q}, 64'd0);
      chk("mid_late_data_ok", {62'd0, s_data_ok}, 64'd0);
      chk("mid_post_m_req", {63'd0, m_req}, 64'd0);
      tick();
      m_data_ok = 1'b0;
      #2;
      chk("mid_late_count", {62'd0, dut.u_owner_fifo.count_q}, 64'd0);

      // Traffic works again after the mid-operation reset
      s_req = 2'b01; m_addr_ok = 1'b1;
      #2;
      chk("post_acc", {62'd0, s_addr_ok}, 64'd1);
      expect_resp(1'b0, 32'h5555_AAAA);
      tick();
      s_req = '0; m_addr_ok = 1'b0;
      respond("post_r0");
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2: maximum outstanding accepted requests (power of 2, >=2).
REQ-002 SHALL have port clk  in  1  single clock, all state on posedge.
REQ-003 SHALL have port resetn  in  1  synchronous, active-low reset.
REQ-004 SHALL have port s_req  in  2  per-requester request; bit0 = inst, bit1 = data.
REQ-005 SHALL have port s_wr  in  2  per-requester write flag.
REQ-006 SHALL have port s_size  in  4  per-requester size, 2 bits each (0 = byte, 1 = half, 2 = word).
REQ-007 SHALL have port s_wstrb  in  8  per-requester byte strobes, 4 bits each.
REQ-008 SHALL have port s_addr  in  64  per-requester address, 32 bits each.
REQ-009 SHALL have port s_wdata  in  64  per-requester write data, 32 bits each.
REQ-010 SHALL have port s_addr_ok  out  2  per-requester request accepted.
REQ-011 SHALL have port s_data_ok  out  2  per-requester response valid.
REQ-012 SHALL have port s_rdata  out  32  response data, shared by both requesters.
REQ-013 SHALL have port m_req  out  1  request to the shared SRAM-like port.
REQ-014 SHALL have ports m_wr/m_size/m_wstrb/m_addr/m_wdata  out  1/2/4/32/32  fields of the granted request.
REQ-015 SHALL have port m_addr_ok  in  1  shared port accepted m_req.
REQ-016 SHALL have port m_data_ok  in  1  shared port returns a response.
REQ-017 SHALL have port m_rdata  in  32  response data.

Function
REQ-018 SHALL forward the granted requester's fields combinationally onto m_* and assert m_req = s_req[grant] while issue is permitted.
REQ-019 SHALL grant by fixed priority: data (bit1) over inst (bit0) when no lock is held.
REQ-020 SHALL set a lock on the current grant when m_req=1 and m_addr_ok=0.
REQ-021 SHALL keep the grant fixed while the lock is held, even if the other requester asserts.
REQ-022 SHALL clear the lock on the cycle m_req & m_addr_ok (the handshake).
REQ-023 SHALL drive s_addr_ok[grant] = m_addr_ok & m_req, and 0 for the non-granted requester.
REQ-024 SHALL push the grant index into an in-order owner FIFO of DEPTH entries on each handshake.
REQ-025 SHALL pop the owner FIFO on m_data_ok, drive s_data_ok[head] = 1 for one cycle, and pass s_rdata = m_rdata combinationally.
REQ-026 SHALL hold m_req = 0 when the FIFO is full, including a cycle that also has a pop; a held lock stays held.
REQ-027 SHALL update the FIFO count by +1 on push, -1 on pop, and leave it unchanged on a simultaneous push and pop.
REQ-028 SHALL wrap the FIFO read/write pointers modulo DEPTH.
REQ-029 SHALL ignore m_data_ok while the FIFO is empty: s_data_ok = 0, no state change.
REQ-030 SHALL give zero added latency: requester to m_req, handshake to s_addr_ok, and m_data_ok to s_data_ok are all combinational paths.
REQ-031 SHALL return responses to each requester in acceptance order; a write handshake also receives exactly one data_ok.

Reset
REQ-032 SHALL, on resetn=0 at posedge clk, clear the lock, set the grant to data, and set FIFO count and pointers to 0.
REQ-033 SHALL hold m_req, s_addr_ok and s_data_ok at 0 during reset, and after reset until a new request arrives.
REQ-034 SHALL discard in-flight requests on a mid-operation reset; a later m_data_ok is then ignored per REQ-029.

Structure
REQ-035 SHALL place the requester index constants (REQ_INST=0, REQ_DATA=1) and the size encodings in the shared pipeline package.
REQ-036 SHALL implement the owner FIFO as the sub-module owner_fifo (parameter DEPTH, 1-bit entries, push/pop/full/empty/head).

Verification
REQ-037 SHALL cover simultaneous requests: s_req=2'b11, m_addr_ok=1 -> s_addr_ok=2'b10 and m_addr=data address; s_addr_ok=2'b01 on the next cycle.
REQ-038 SHALL cover the lock: inst request with m_addr_ok=0 for 3 cycles while data rises in cycle 2 -> grant stays inst, m_addr constant, inst accepted first.
REQ-039 SHALL cover the full FIFO (DEPTH=2): two accepts without data_ok -> m_req=0 on the third request; after one m_data_ok, m_req=1 on the next cycle.
REQ-040 SHALL cover ordering: accept inst then data, return m_rdata 0xAAAA0000 then 0xBBBB0000 -> s_data_ok=01 with 0xAAAA0000, then 10 with 0xBBBB0000.
REQ-041 SHALL cover a spurious response: m_data_ok=1 with an empty FIFO -> s_data_ok=00 and count stays 0.
REQ-042 SHALL cover reset mid-operation: resetn=0 with 1 outstanding -> outputs 0 and count 0; a later m_data_ok is ignored.
